pingpong_buffer_reader: RTL

- Consumer-side controller for the ping-pong buffer pair; the other end of the writer that fills a bank and flags it busy/full.
- Waits for a filled bank, reads its words through the bank's synchronous read port (1-cycle latency), and streams them out on a valid/ready interface.
- Returns the bank to the writer with a one-cycle release pulse when the last word has been accepted.
- Sits between the two single-buffer banks and the downstream compute stage.

---
 rtl/pingpong_buffer_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pingpong_buffer_reader.sv
// Consumer side of the ping-pong buffer pair: drains filled banks in strict
// alternation onto a valid/ready stream and hands each bank back with a release pulse.
module pingpong_buffer_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        bank_full,
   input  logic [ADDR_W:0]   bank_len0,
   input  logic [ADDR_W:0]   bank_len1,
   output logic              rd_en,
   output logic              rd_bank,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic [1:0]        bank_release,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_RELEASE
   } state_t;

   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic              next_bank_q, next_bank_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q;
   logic              inflight_last_q;

   logic [DATA_W-1:0] fifo_data_q [2];
   logic              fifo_last_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q, count_d;

   logic              push;
   logic              pop;
   logic [2:0]        occupancy;
   logic              issue_ok;
   logic [ADDR_W:0]   sel_len;

   assign m_valid = (count_q != 2'd0);
   assign m_data  = fifo_data_q[rd_ptr_q];
   assign m_last  = fifo_last_q[rd_ptr_q];
   assign pop     = m_valid & m_ready;
   assign push    = inflight_q;

   // Words queued or one cycle from arriving must leave room in the 2-entry FIFO.
   assign occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
   assign issue_ok  = (occupancy < 3'd2);
   assign count_d   = count_q + 2'(push) - 2'(pop);

   assign sel_len = next_bank_q ? bank_len1 : bank_len0;
   assign busy    = (state_q != ST_IDLE);
   assign rd_bank = next_bank_q;
   assign rd_addr = addr_q;

   always_comb begin
      state_d      = state_q;
      next_bank_d  = next_bank_q;
      remaining_d  = remaining_q;
      addr_d       = addr_q;
      rd_en        = 1'b0;
      bank_release = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (bank_full[next_bank_q]) begin
               remaining_d = sel_len;
               addr_d      = '0;
               state_d     = (sel_len == '0) ? ST_RELEASE : ST_READ;
            end
         end
         ST_READ: begin
            if (issue_ok) begin
               rd_en       = 1'b1;
               remaining_d = remaining_q - LEN_ONE;
               addr_d      = addr_q + ADDR_ONE;
               if (remaining_q == LEN_ONE) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && m_last) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            bank_release = next_bank_q ? 2'b10 : 2'b01;
            next_bank_d  = ~next_bank_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         next_bank_q     <= 1'b0;
         remaining_q     <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         next_bank_q     <= next_bank_d;
         remaining_q     <= remaining_d;
         addr_q          <= addr_d;
         inflight_q      <= rd_en;
         inflight_last_q <= rd_en & (remaining_q == LEN_ONE);
      end
   end

   // Reset also clears storage so m_data reads 0 straight after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            fifo_data_q[wr_ptr_q] <= rd_data;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (count_q == 2'd2)));
   assert property (@(posedge clk) disable iff (rst)
      (state_q != ST_READ) || (remaining_q != '0));

endmodule
